// File: rtl/io_pkg.sv
// io_pkg: shared I/O bus field positions, access modes and default word map
package io_pkg;
    localparam int WORD_LSB = 2;
    localparam int WORD_MSB = 7;
    localparam int MODE_LSB = 8;
    localparam int MODE_MSB = 9;
    localparam int unsigned DEF_BASE_WORD = 42;
    localparam int unsigned DEF_PULSE_WORD = 50;

    typedef enum logic [1:0] {
        MODE_WRITE = 2'b00,
        MODE_SET   = 2'b01,
        MODE_CLR   = 2'b10,
        MODE_TOG   = 2'b11
    } io_mode_e;

    function automatic logic [31:0] apply_mode(io_mode_e mode, logic [31:0] cur, logic [31:0] d);
        return mode == MODE_WRITE ? d : mode == MODE_SET ? cur | d : mode == MODE_CLR ? cur & ~d : cur ^ d;
    endfunction
endpackage

// File: rtl/io_pulse_timer.sv
// io_pulse_timer: self-clearing one-shot pulse bits held for PULSE_CYCLES cycles after the last load
module io_pulse_timer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PULSE_CYCLES = 16
) (
    input  logic             io_clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] pulse_out,
    output logic             pulse_busy
);
    localparam int unsigned CW = PULSE_CYCLES > 1 ? $clog2(PULSE_CYCLES) : 1;

    logic [CW-1:0] count;

    // a non-zero load wins over expiry so retriggering never drops the pulse
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            pulse_out <= '0;
            pulse_busy <= 1'b0;
            count <= '0;
        end else if (load && din != '0) begin
            pulse_out <= pulse_out | din;
            pulse_busy <= 1'b1;
            count <= CW'(PULSE_CYCLES - 1);
        end else if (pulse_busy) begin
            if (count == '0) begin
                pulse_out <= '0;
                pulse_busy <= 1'b0;
            end else
                count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/io_output_bank.sv
// io_output_bank: memory-mapped output ports with write/set/clear/toggle access,
// registered readback, change strobes and a one-shot pulse register
module io_output_bank
    import io_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BASE_WORD = DEF_BASE_WORD,
    parameter int unsigned PULSE_WORD = DEF_PULSE_WORD,
    parameter int unsigned PULSE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       io_clk,
    input  logic                       resetn,
    input  logic [31:0]                addr,
    input  logic [31:0]                datain,
    input  logic                       write_io_enable,
    input  logic                       read_io_enable,
    output logic [31:0]                dataout,
    output logic [NUM_PORTS*WIDTH-1:0] out_ports,
    output logic [NUM_PORTS-1:0]       port_updated,
    output logic [WIDTH-1:0]           pulse_out,
    output logic                       pulse_busy
);
    if (NUM_PORTS < 1 || NUM_PORTS > 8 || WIDTH < 1 || WIDTH > 32 || PULSE_CYCLES < 1 ||
        BASE_WORD + NUM_PORTS > 64 || PULSE_WORD > 63 ||
        (PULSE_WORD >= BASE_WORD && PULSE_WORD < BASE_WORD + NUM_PORTS)) begin : g_param_error
        $error("io_output_bank: invalid parameter set");
    end

    logic [5:0]       word;
    io_mode_e         mode;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] port_val [NUM_PORTS];
    logic [31:0]      rd_data;
    logic             unused_bits;

    assign word = addr[WORD_MSB:WORD_LSB];
    assign mode = io_mode_e'(addr[MODE_MSB:MODE_LSB]);
    assign d = datain[WIDTH-1:0];
    assign unused_bits = ^{addr[31:MODE_MSB+1], addr[WORD_LSB-1:0], datain};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] nxt;
        logic             hit;
        logic             upd;
        assign hit = write_io_enable && word == 6'(BASE_WORD + p);
        assign nxt = WIDTH'(apply_mode(mode, 32'(q), 32'(d)));
        // strobe only on a real change, aligned with the new register value
        always_ff @(posedge io_clk or negedge resetn) begin
            if (!resetn) begin
                q <= RESET_VALUE;
                upd <= 1'b0;
            end else begin
                upd <= hit && nxt != q;
                if (hit) q <= nxt;
            end
        end
        assign out_ports[p*WIDTH +: WIDTH] = q;
        assign port_updated[p] = upd;
        assign port_val[p] = q;
    end

    io_pulse_timer #(
        .WIDTH(WIDTH),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_pulse (
        .io_clk(io_clk),
        .resetn(resetn),
        .load(write_io_enable && word == 6'(PULSE_WORD)),
        .din(d),
        .pulse_out(pulse_out),
        .pulse_busy(pulse_busy)
    );

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (word == 6'(BASE_WORD + p)) rd_data = 32'(port_val[p]);
        if (word == 6'(PULSE_WORD)) begin
            rd_data = 32'(pulse_out);
            rd_data[31] = pulse_busy;
        end
    end

    // sampled from pre-write register values, giving read-before-write
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn)
            dataout <= '0;
        else if (read_io_enable)
            dataout <= rd_data;
    end
endmodule

// File: doc/io_output_bank.md
Name: io_output_bank

Overview:
Parametrised memory-mapped output-port bank replacing the single-register output block on the CPU I/O bus. It provides NUM_PORTS registered output ports of WIDTH bits. Each port supports direct write and atomic set, clear and toggle access modes. The block adds registered readback, per-port change strobes, and a self-clearing one-shot pulse register driven by a cycle counter.

Parameters:
NUM_PORTS, 4, number of output ports (1..8)
WIDTH, 32, bits per port (1..32); datain[WIDTH-1:0] used, upper bits ignored
BASE_WORD, 6'd42, word index (addr[7:2]) of port 0; ports occupy BASE_WORD..BASE_WORD+NUM_PORTS-1
PULSE_WORD, 6'd50, word index of the one-shot pulse register
PULSE_CYCLES, 16, pulse duration in io_clk cycles (>=1)
RESET_VALUE, 0, reset value of every port register

Ports:
io_clk  in  1  bus/I/O clock, rising edge
resetn  in  1  asynchronous active-low reset
addr  in  32  byte address; [7:2] word select, [9:8] access mode
datain  in  32  write data
write_io_enable  in  1  write strobe, one cycle per access
read_io_enable  in  1  read strobe
dataout  out  32  registered read data, zero-extended
out_ports  out  NUM_PORTS*WIDTH  port p at bits [p*WIDTH +: WIDTH]
port_updated  out  NUM_PORTS  one-cycle strobe, port value changed
pulse_out  out  WIDTH  one-shot pulse bits
pulse_busy  out  1  pulse counter running

Behaviour:
- Reset (resetn=0, asynchronous): every port = RESET_VALUE; dataout=0; port_updated=0; pulse_out=0; pulse_busy=0; counter=0. Reset asserted mid-pulse kills the pulse immediately.
- Port decode: hit when write_io_enable=1 and BASE_WORD <= addr[7:2] < BASE_WORD+NUM_PORTS. Port index p = addr[7:2]-BASE_WORD.
- Mode addr[9:8]: 00 WRITE (port=d), 01 SET (port|=d), 10 CLR (port&=~d), 11 TOGGLE (port^=d), where d=datain[WIDTH-1:0].
- Write latency: out_ports reflects the new value the cycle after the write edge (one register stage).
- port_updated[p]: high for exactly one cycle, coincident with the new out_ports value, only if the value actually changed. A write of an equal value gives no strobe.
- Unmapped write addresses: no state change, no strobe.
- Pulse register, write at PULSE_WORD with any mode bits:
  - if d != 0: pulse_out <= pulse_out | d; counter <= PULSE_CYCLES-1; pulse_busy <= 1.
  - d == 0 is a no-op and does not restart the counter.
- Pulse countdown:
  - While busy and no new pulse write, the counter decrements each cycle.
  - On the cycle the counter reaches 0, next edge: pulse_out <= 0, pulse_busy <= 0.
  - Total high time from a single write is exactly PULSE_CYCLES cycles.
- Pulse write during an active pulse: bits are ORed and the counter restarts. This write takes priority over expiry in the same cycle.
- Readback: read_io_enable=1 registers dataout next cycle.
  - Port word: zero-extended current port value. Mode bits are ignored.
  - PULSE_WORD: {pulse_busy at bit 31, pulse_out zero-extended}; bit 31 is overridden by busy when WIDTH=32.
  - Unmapped word: 0.
  - When read_io_enable=0, dataout holds its value.
- Simultaneous read and write of the same port: dataout returns the pre-write value (read-before-write).
- Elaboration error if BASE_WORD+NUM_PORTS > 64, if PULSE_WORD falls inside the port range, or if a parameter is out of range.

Decomposition:
- Shared package io_pkg:
  - mode encodings MODE_WRITE=2'b00, MODE_SET=2'b01, MODE_CLR=2'b10, MODE_TOG=2'b11
  - address field positions (WORD_LSB=2, WORD_MSB=7, MODE_LSB=8, MODE_MSB=9)
  - default BASE_WORD/PULSE_WORD constants, for sharing with io_input and the software header
- Sub-module io_pulse_timer: pulse register, counter and busy flag, parametrised by WIDTH and PULSE_CYCLES.
- Port registers, decode and readback mux stay in the top level via a generate loop.

Test Plan:
- Reset: hold resetn=0 with writes active -> out_ports=0, dataout=0, pulse_out=0. Release, then WRITE port0 = 0x12345678 -> out_ports[31:0]=0x12345678 next cycle, port_updated=4'b0001 for one cycle.
- Modes on port2, starting from WRITE 0x00FF: SET 0xF000 -> 0xF0FF; CLR 0x000F -> 0xF0F0; TOGGLE 0xFFFF -> 0x0F0F. Each step gives one port_updated[2] strobe. Repeating SET 0xF000 on 0x0F0F -> 0xFF0F with a strobe; SET 0xF000 again -> no strobe.
- Pulse, PULSE_CYCLES=16: write 0x5 at PULSE_WORD -> pulse_out=0x5 and pulse_busy=1 for exactly 16 cycles, then both 0. Write 0 -> no effect.
- Pulse retrigger: write 0x1, then 0x2 ten cycles later -> pulse_out=0x3 from that point, 16 more cycles, then 0. Assert resetn=0 mid-pulse -> pulse_out=0 asynchronously.
- Readback: read port3 after WRITE 0xA5 (WIDTH=8) -> dataout=0x000000A5. Read PULSE_WORD while busy with 0x4 -> 0x80000004. Read an unmapped word -> 0. Same-cycle read and write of port1 -> old value returned.
- Decode boundaries: write word BASE_WORD-1 and word BASE_WORD+NUM_PORTS -> no state change, no strobes.
